// File: rtl/fp_add_pkg.sv
// Shared constants, issue-register record and small field helpers for the
// two-requester floating-point adder arbiter.
package fp_add_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = 24;
  localparam int FP_W  = 32;

  // Issue register contents: operand pair, owning requester and occupancy.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            tag;
    logic            valid;
  } issue_t;

  // Which requester wins when both are eligible.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  // Biased exponent field of a single-precision word.
  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2:MAN_W];
  endfunction

  // Significand with the hidden leading one restored.
  function automatic logic [SIG_W-1:0] fp_sig(input logic [FP_W-1:0] x);
    return {1'b1, x[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational positive-only single-precision adder: align the smaller
// operand by truncating right shift, add significands, renormalise on carry.
module fp_add_core
  import fp_add_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic [EXP_W-1:0] big_exp_s;
  logic [EXP_W-1:0] small_exp_s;
  logic [SIG_W-1:0] big_sig_s;
  logic [SIG_W-1:0] small_sig_s;
  logic [EXP_W-1:0] diff_s;
  logic [SIG_W-1:0] shifted_s;
  logic [SIG_W:0]   add_s;
  logic [EXP_W-1:0] res_exp_s;
  logic [MAN_W-1:0] res_man_s;

  // Order operands by exponent, align, add and normalise; ties pick a, which
  // gives the same result as picking b because no shift happens.
  always_comb begin
    big_exp_s   = fp_exp(a);
    small_exp_s = fp_exp(b);
    big_sig_s   = fp_sig(a);
    small_sig_s = fp_sig(b);
    if (fp_exp(a) >= fp_exp(b)) begin
      big_exp_s   = fp_exp(a);
      small_exp_s = fp_exp(b);
      big_sig_s   = fp_sig(a);
      small_sig_s = fp_sig(b);
    end else begin
      big_exp_s   = fp_exp(b);
      small_exp_s = fp_exp(a);
      big_sig_s   = fp_sig(b);
      small_sig_s = fp_sig(a);
    end

    diff_s = big_exp_s - small_exp_s;
    if (diff_s >= 8'd24) begin
      shifted_s = {SIG_W{1'b0}};
    end else begin
      shifted_s = small_sig_s >> diff_s;
    end

    add_s = {1'b0, big_sig_s} + {1'b0, shifted_s};
    if (add_s[SIG_W]) begin
      res_exp_s = big_exp_s + 8'd1;
      res_man_s = add_s[SIG_W-1:1];
    end else begin
      res_exp_s = big_exp_s;
      res_man_s = add_s[MAN_W-1:0];
    end

    sum = {1'b0, res_exp_s, res_man_s};
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Two requesters share one adder: round-robin grant into an issue register,
// then the sum lands in a per-requester result slot held until consumed.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [FP_W-1:0] rsp0_sum,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [FP_W-1:0] rsp1_sum,
  output logic            busy
);

  localparam prio_e PRIO_INIT = (RR_INIT == 0) ? PRIO_REQ0 : PRIO_REQ1;

  issue_t          issue_r;
  issue_t          issue_nxt_s;
  prio_e           prio_r;
  prio_e           prio_nxt_s;
  logic            rsp0_valid_r;
  logic            rsp1_valid_r;
  logic [FP_W-1:0] rsp0_sum_r;
  logic [FP_W-1:0] rsp1_sum_r;
  logic [FP_W-1:0] core_sum_s;
  logic            elig0_s;
  logic            elig1_s;
  logic            grant0_s;
  logic            grant1_s;
  logic            wr0_s;
  logic            wr1_s;
  logic            cons0_s;
  logic            cons1_s;

  fp_add_core u_core (
    .a   (issue_r.a),
    .b   (issue_r.b),
    .sum (core_sum_s)
  );

  // Eligibility, single-winner grant and next issue/priority state.
  always_comb begin
    cons0_s = rsp0_valid_r && rsp0_ready;
    cons1_s = rsp1_valid_r && rsp1_ready;
    wr0_s   = issue_r.valid && (issue_r.tag == 1'b0);
    wr1_s   = issue_r.valid && (issue_r.tag == 1'b1);
    elig0_s = req0_valid && !wr0_s && (!rsp0_valid_r || cons0_s);
    elig1_s = req1_valid && !wr1_s && (!rsp1_valid_r || cons1_s);

    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      grant0_s = (prio_r == PRIO_REQ0);
      grant1_s = (prio_r == PRIO_REQ1);
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end

    issue_nxt_s       = issue_r;
    issue_nxt_s.valid = 1'b0;
    prio_nxt_s        = prio_r;
    if (grant0_s) begin
      issue_nxt_s = '{a: req0_a, b: req0_b, tag: 1'b0, valid: 1'b1};
      prio_nxt_s  = PRIO_REQ1;
    end else if (grant1_s) begin
      issue_nxt_s = '{a: req1_a, b: req1_b, tag: 1'b1, valid: 1'b1};
      prio_nxt_s  = PRIO_REQ0;
    end else begin
      issue_nxt_s.valid = 1'b0;
      prio_nxt_s        = prio_r;
    end
  end

  // Issue register and round-robin priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_r <= '{a: 32'h0000_0000, b: 32'h0000_0000, tag: 1'b0, valid: 1'b0};
      prio_r  <= PRIO_INIT;
    end else begin
      issue_r <= issue_nxt_s;
      prio_r  <= prio_nxt_s;
    end
  end

  // Result slot 0: filled from the adder, emptied on consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_r <= 1'b0;
      rsp0_sum_r   <= 32'h0000_0000;
    end else if (wr0_s) begin
      rsp0_valid_r <= 1'b1;
      rsp0_sum_r   <= core_sum_s;
    end else if (cons0_s) begin
      rsp0_valid_r <= 1'b0;
    end
  end

  // Result slot 1: filled from the adder, emptied on consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid_r <= 1'b0;
      rsp1_sum_r   <= 32'h0000_0000;
    end else if (wr1_s) begin
      rsp1_valid_r <= 1'b1;
      rsp1_sum_r   <= core_sum_s;
    end else if (cons1_s) begin
      rsp1_valid_r <= 1'b0;
    end
  end

  // Output drive; grants are masked while reset is asserted.
  always_comb begin
    req0_ready = grant0_s && !rst;
    req1_ready = grant1_s && !rst;
    rsp0_valid = rsp0_valid_r;
    rsp1_valid = rsp1_valid_r;
    rsp0_sum   = rsp0_sum_r;
    rsp1_sum   = rsp1_sum_r;
    busy       = issue_r.valid || rsp0_valid_r || rsp1_valid_r;
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench: reset checks, directed vectors, multi-cycle corner
// sequences and a randomized run against a behavioural reference model.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_sum, rsp1_sum;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp_add_arbiter #(.RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_sum   (rsp0_sum),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_sum   (rsp1_sum),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Reference adder from plain integer arithmetic on value = sig * 2^exp.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    longint ex, ey, mx, my, eb, mb, ms, d, s;
    logic [31:0] r;
    ex = longint'(x[30:23]);
    ey = longint'(y[30:23]);
    mx = 64'd8388608 + longint'(x[22:0]);
    my = 64'd8388608 + longint'(y[22:0]);
    if (ex >= ey) begin
      eb = ex; mb = mx; ms = my; d = ex - ey;
    end else begin
      eb = ey; mb = my; ms = mx; d = ey - ex;
    end
    if (d >= 64'd24) ms = 64'd0;
    else ms = ms / (64'd1 << d);
    s = mb + ms;
    if (s >= 64'd16777216) begin
      s  = s / 64'd2;
      eb = eb + 64'd1;
    end
    r = 32'h0000_0000;
    r[30:23] = eb[7:0];
    r[22:0]  = s[22:0];
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = 32'h0000_0000;
    if ($urandom_range(1, 0) == 1) r[30:23] = 8'($urandom_range(135, 120));
    else r[30:23] = 8'($urandom_range(253, 1));
    r[22:0] = 23'($urandom);
    return r;
  endfunction

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'h0000_0000; req0_b = 32'h0000_0000;
    req1_a = 32'h0000_0000; req1_b = 32'h0000_0000;
  endtask

  task automatic drain();
    nxt();
    idle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4) nxt();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic rdy, vld;
    logic [31:0] sm;
    nxt();
    if (v.port == 1'b0) begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; end
    else begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; end
    #1;
    rdy = (v.port == 1'b0) ? req0_ready : req1_ready;
    chk("vec_ready", {31'd0, rdy}, 32'd1);
    nxt();
    idle();
    #1;
    vld = (v.port == 1'b0) ? rsp0_valid : rsp1_valid;
    chk("vec_rsp_valid_t1", {31'd0, vld}, 32'd0);
    nxt();
    #1;
    vld = (v.port == 1'b0) ? rsp0_valid : rsp1_valid;
    sm  = (v.port == 1'b0) ? rsp0_sum : rsp1_sum;
    chk("vec_rsp_valid_t2", {31'd0, vld}, 32'd1);
    chk("vec_sum", sm, v.exp);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nxt();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    vld = (v.port == 1'b0) ? rsp0_valid : rsp1_valid;
    chk("vec_consumed", {31'd0, vld}, 32'd0);
  endtask

  initial begin
    int grants1;
    bit outst[2];
    int gcyc[2];
    logic [31:0] esum[2];
    bit prio;
    bit vis[2], elig[2], g[2];

    vecs[0] = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    vecs[1] = '{1'b1, 32'h3FC0_0000, 32'h4000_0000, 32'h4060_0000};
    vecs[2] = '{1'b1, 32'h4000_0000, 32'h3FC0_0000, 32'h4060_0000};
    vecs[3] = '{1'b0, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000};
    vecs[4] = '{1'b0, 32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001};
    vecs[5] = '{1'b1, 32'h3F80_0000, 32'h4C00_0000, 32'h4C00_0000};
    vecs[6] = '{1'b0, 32'h4049_0FDB, 32'h3F80_0000, 32'h4084_87ED};
    vecs[7] = '{1'b1, 32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000};

    // Reset state, with requests offered to prove readies are masked.
    rst = 1'b1;
    idle();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    nxt();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_sum", rsp0_sum, 32'h0000_0000);
    chk("rst_rsp1_sum", rsp1_sum, 32'h0000_0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Contention right after reset: req0 first, req1 next cycle.
    nxt();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F00_0000;
    #1;
    chk("both_t0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("both_t0_ready1", {31'd0, req1_ready}, 32'd0);
    nxt();
    #1;
    chk("both_t1_ready0", {31'd0, req0_ready}, 32'd0);
    chk("both_t1_ready1", {31'd0, req1_ready}, 32'd1);
    nxt();
    idle();
    #1;
    chk("both_t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("both_t2_rsp0_sum", rsp0_sum, 32'h4000_0000);
    chk("both_t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("both_t2_busy", {31'd0, busy}, 32'd1);
    nxt();
    #1;
    chk("both_t3_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("both_t3_rsp1_sum", rsp1_sum, 32'h3FC0_0000);
    drain();
    #1;
    chk("drained_busy", {31'd0, busy}, 32'd0);

    // Directed arithmetic vectors.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Held result blocks req0 while req1 keeps issuing; release lets req0 in.
    drain();
    nxt();
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    #1;
    chk("hold_grant0", {31'd0, req0_ready}, 32'd1);
    nxt();
    idle();
    nxt();
    #1;
    chk("hold_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    grants1 = 0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      req0_valid = 1'b1; req0_a = 32'h3FC0_0000; req0_b = 32'h4000_0000;
      req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
      rsp1_ready = 1'b1;
      #1;
      chk("hold_ready0_low", {31'd0, req0_ready}, 32'd0);
      chk("hold_rsp0_stable", rsp0_sum, 32'h4000_0000);
      if (req1_ready) grants1++;
    end
    chk("hold_req1_grants", grants1, 32'd2);
    nxt();
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    chk("release_ready0", {31'd0, req0_ready}, 32'd1);
    nxt();
    idle();
    rsp0_ready = 1'b0;
    nxt();
    #1;
    chk("release_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("release_rsp0_sum", rsp0_sum, 32'h4060_0000);

    // Reset with both slots full, priority left on req1.
    drain();
    nxt();
    req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    #1;
    chk("pre_rst_ready1", {31'd0, req1_ready}, 32'd1);
    nxt();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3FC0_0000; req0_b = 32'h4000_0000;
    #1;
    chk("pre_rst_ready0", {31'd0, req0_ready}, 32'd1);
    nxt();
    idle();
    nxt();
    nxt();
    #1;
    chk("pre_rst_full0", {31'd0, rsp0_valid}, 32'd1);
    chk("pre_rst_full1", {31'd0, rsp1_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_rst_rsp0_sum", rsp0_sum, 32'h0000_0000);
    chk("mid_rst_rsp1_sum", rsp1_sum, 32'h0000_0000);
    nxt();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("post_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("post_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);

    // Randomized run from a clean reset against the reference model.
    drain();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    outst[0] = 1'b0; outst[1] = 1'b0;
    gcyc[0] = 0; gcyc[1] = 0;
    esum[0] = 32'h0; esum[1] = 32'h0;
    prio = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      req0_valid = ($urandom_range(9, 0) < 7);
      req1_valid = ($urandom_range(9, 0) < 7);
      req0_a = rand_fp(); req0_b = rand_fp();
      req1_a = rand_fp(); req1_b = rand_fp();
      rsp0_ready = ($urandom_range(1, 0) == 1);
      rsp1_ready = ($urandom_range(1, 0) == 1);
      #1;
      for (int n = 0; n < 2; n++) vis[n] = outst[n] && (cyc >= gcyc[n] + 2);
      elig[0] = req0_valid && (!outst[0] || (vis[0] && rsp0_ready));
      elig[1] = req1_valid && (!outst[1] || (vis[1] && rsp1_ready));
      g[0] = elig[0] && (!elig[1] || prio == 1'b0);
      g[1] = elig[1] && (!elig[0] || prio == 1'b1);
      chk("rand_ready0", {31'd0, req0_ready}, {31'd0, g[0]});
      chk("rand_ready1", {31'd0, req1_ready}, {31'd0, g[1]});
      chk("rand_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, vis[0]});
      chk("rand_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, vis[1]});
      chk("rand_busy", {31'd0, busy}, {31'd0, outst[0] || outst[1]});
      if (vis[0]) chk("rand_rsp0_sum", rsp0_sum, esum[0]);
      if (vis[1]) chk("rand_rsp1_sum", rsp1_sum, esum[1]);
      if (vis[0] && rsp0_ready) outst[0] = 1'b0;
      if (vis[1] && rsp1_ready) outst[1] = 1'b0;
      if (g[0]) begin
        outst[0] = 1'b1; gcyc[0] = cyc; esum[0] = ref_add(req0_a, req0_b); prio = 1'b1;
      end
      if (g[1]) begin
        outst[1] = 1'b1; gcyc[1] = cyc; esum[1] = ref_add(req1_a, req1_b); prio = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester that holds priority after reset (0 or 1).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  in  1  requester N offers an operand pair.
REQ-005 Port: req0_ready / req1_ready  out  1  requester N's operands are accepted this cycle (grant).
REQ-006 Port: req0_a, req0_b / req1_a, req1_b  in  32  IEEE-754 single operands; sign bit ignored.
REQ-007 Port: rsp0_valid / rsp1_valid  out  1  result for requester N is held.
REQ-008 Port: rsp0_ready / rsp1_ready  in  1  requester N consumes its result.
REQ-009 Port: rsp0_sum / rsp1_sum  out  32  result for requester N.
REQ-010 Port: busy  out  1  high while the issue stage or either result slot is occupied.

Function
REQ-011 One shared adder datapath; two-stage pipeline: issue register (operands + 1-bit tag + valid), then one result slot per requester.
REQ-012 A transfer occurs when reqN_valid && reqN_ready; a result is consumed when rspN_valid && rspN_ready.
REQ-013 Requester N is eligible when reqN_valid, the issue register does not hold tag N, and the result slot for N is empty or being consumed this cycle.
REQ-014 At most one grant per cycle; reqN_ready is combinational from eligibility and priority and never depends on reqN_valid of the other port's ready.
REQ-015 Exactly one eligible requester: it is granted regardless of priority.
REQ-016 Both eligible: the priority holder is granted; after any grant, priority moves to the other requester.
REQ-017 No grant: priority unchanged.
REQ-018 Granted operands load the issue register at the edge. On the next edge, the adder output writes result slot [tag] and the issue register clears unless a new grant occurs in the same cycle.
REQ-019 Latency: a grant in cycle T gives rspN_valid=1 and valid rspN_sum from cycle T+2.
REQ-020 Throughput: one issue per cycle across both requesters; one issue per 2 cycles per requester.
REQ-021 rspN_sum and rspN_valid stay stable until consumed. Consuming and refilling the same slot in one cycle keeps rspN_valid=1 with the new sum.
REQ-022 Adder arithmetic, positive operands only:
- hidden bit 1 prepended to both 23-bit mantissas;
- the smaller-exponent mantissa is right-shifted by the exponent difference, truncating shifted-out bits;
- a difference of 24 or more gives a zero shifted value;
- 24-bit add; on carry-out, the sum is shifted right 1 and the larger exponent incremented;
- result sign 0.
REQ-023 Equal exponents: either operand may be treated as the larger one; the result is identical either way.
REQ-024 Operands with exponent 0x00 or 0xFF are out of scope; the result is deterministic but unspecified, and the handshake is unaffected.

Reset
REQ-025 While rst is high:
- issue-register valid, rsp0_valid, rsp1_valid and busy are 0;
- rsp0_sum and rsp1_sum are 0x00000000;
- priority = RR_INIT;
- req0_ready and req1_ready are 0.
REQ-026 Reset asserted mid-operation discards in-flight and held results; no stale result is presented after deassertion.
REQ-027 First grant possible in the first cycle after rst deasserts.

Structure
REQ-028 Shared package fp_add_pkg holds the constants EXP_W=8, MAN_W=23, SIG_W=24 and the issue-register record type (a, b, tag, valid).
REQ-029 Combinational sub-module fp_add_core implements REQ-022/023; the arbiter owns all registers and handshake logic.

Verification
REQ-030 req0 alone with 0x3F800000 + 0x3F800000 -> req0_ready in cycle T; rsp0_valid at T+2 with 0x40000000.
REQ-031 req0 0x40000000 + req1 0x3FC00000 (1.5), both valid in the same cycle, RR_INIT=0 -> req0 granted at T, req1 at T+1, rsp1_sum=0x3FC00000 at T+3.
REQ-032 req1 0x3FC00000 + 0x40000000 -> rsp1_sum=0x40600000 (3.5); the operands swapped give the same result.
REQ-033 req0 0x4B800000 + 0x3F800000 (exponent difference 24) -> rsp0_sum=0x4B800000.
REQ-034 rsp0_ready held low with the result held -> req0_ready stays 0 while req1 keeps issuing; raising rsp0_ready lets req0 issue in that same cycle.
REQ-035 rst pulsed while both slots are full -> rsp0_valid=rsp1_valid=0 and sums 0 immediately; priority = RR_INIT after deassertion.
